// File: rtl/game_pkg.sv
// Shared game-side types and screen constants for the meteor spawn path.
// Used by meteor_spawn_scheduler and other random-placement blocks.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SEARCH = 2'd2,
        ISSUE  = 2'd3
    } state_e;

    localparam int unsigned SCREEN_W      = 640;
    localparam int unsigned METEOR_W      = 32;
    localparam int unsigned X_MAX         = SCREEN_W - METEOR_W - 1;
    localparam int unsigned X_W           = 10;
    localparam int unsigned LFSR_W        = 10;
    localparam int unsigned DEF_NUM_SLOTS = 8;
    localparam int unsigned SLOT_W        = $clog2(DEF_NUM_SLOTS);

    typedef logic [SLOT_W-1:0] slot_idx_t;

    // Fold a raw LFSR value into 0..X_MAX so a meteor never starts off-screen.
    function automatic logic [X_W-1:0] fold_x(input logic [LFSR_W-1:0] v);
        if (32'(v) > X_MAX) begin
            return X_W'(v - 10'd512);
        end
        return X_W'(v);
    endfunction

endpackage

// File: rtl/lfsr10.sv
// 10-bit Fibonacci LFSR (taps 10,7), advances every clock; seed loaded on reset.
module lfsr10 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [9:0] seed,
    output logic [9:0] out
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/meteor_spawn_scheduler.sv
// Meteor spawn scheduler: interval timer, round-robin free-slot search, valid/ready command.
// Optional difficulty ramp of the spawn interval enabled by METEOR_DIFFICULTY_RAMP_EN.
module meteor_spawn_scheduler
    import game_pkg::*;
#(
    parameter int unsigned NUM_SLOTS      = 8,
    parameter int unsigned SPAWN_INTERVAL = 60,
    parameter int unsigned MIN_INTERVAL   = 15,
    parameter logic [9:0]  LFSR_SEED      = 10'h2A5
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_tick,
    input  logic                         game_active,
    input  logic [NUM_SLOTS-1:0]         slot_busy,
    input  logic                         spawn_ready,
    output logic                         spawn_valid,
    output logic [$clog2(NUM_SLOTS)-1:0] spawn_slot,
    output logic [9:0]                   spawn_x,
    output logic [7:0]                   spawn_count
);

    localparam int unsigned SW     = $clog2(NUM_SLOTS);
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned PCNT_W = SW + 1;

    if (NUM_SLOTS < 2 || NUM_SLOTS > 16 || (NUM_SLOTS & (NUM_SLOTS - 1)) != 0) begin : g_bad_slots
        $error("meteor_spawn_scheduler: NUM_SLOTS must be a power of two in 2..16");
    end
    if (SPAWN_INTERVAL < 1 || SPAWN_INTERVAL > 255 || MIN_INTERVAL < 1 || MIN_INTERVAL > 255) begin : g_bad_interval
        $error("meteor_spawn_scheduler: intervals must be in 1..255");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  frame_q, frame_d;
    logic [CNT_W-1:0]  interval_c;
    logic [SW-1:0]     ptr_q, ptr_d;
    logic [SW-1:0]     probe_q, probe_d;
    logic [PCNT_W-1:0] tries_q, tries_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [9:0]        x_q, x_d;
    logic              valid_q, valid_d;
    logic [7:0]        count_q, count_d;
    logic [9:0]        lfsr_c;
    logic              start_c;
    logic              accept_c;

    lfsr10 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (LFSR_SEED),
        .out   (lfsr_c)
    );

    assign start_c  = (state_q == IDLE) && game_active;
    assign accept_c = (state_q == ISSUE) && game_active && spawn_ready;

`ifdef METEOR_DIFFICULTY_RAMP_EN
    logic [CNT_W-1:0] interval_q, interval_d;

    // Shorten the interval once per 16 accepted spawns, floored at MIN_INTERVAL.
    always_comb begin
        interval_d = interval_q;
        if (start_c) begin
            interval_d = CNT_W'(SPAWN_INTERVAL);
        end else if (accept_c && count_q != 8'hFF && count_q[3:0] == 4'hF
                     && interval_q > CNT_W'(MIN_INTERVAL)) begin
            interval_d = CNT_W'(interval_q - 8'd1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            interval_q <= CNT_W'(SPAWN_INTERVAL);
        end else begin
            interval_q <= interval_d;
        end
    end

    assign interval_c = interval_q;
`else
    assign interval_c = CNT_W'(SPAWN_INTERVAL);
`endif

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        ptr_d   = ptr_q;
        probe_d = probe_q;
        tries_d = tries_q;
        slot_d  = slot_q;
        x_d     = x_q;
        valid_d = valid_q;
        count_d = count_q;

        // Losing game_active abandons whatever is in flight.
        if (!game_active) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    frame_d = '0;
                    ptr_d   = '0;
                    count_d = '0;
                end
                WAIT: begin
                    if (frame_tick) begin
                        if (frame_q == CNT_W'(interval_c - 8'd1)) begin
                            frame_d = '0;
                            probe_d = ptr_q;
                            tries_d = '0;
                            state_d = SEARCH;
                        end else begin
                            frame_d = CNT_W'(frame_q + 8'd1);
                        end
                    end
                end
                SEARCH: begin
                    if (!slot_busy[probe_q]) begin
                        slot_d  = probe_q;
                        x_d     = fold_x(lfsr_c);
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        probe_d = SW'(probe_q + 1'b1);
                        tries_d = PCNT_W'(tries_q + 1'b1);
                        if (tries_q == PCNT_W'(NUM_SLOTS - 1)) begin
                            state_d = WAIT;
                        end
                    end
                end
                ISSUE: begin
                    if (spawn_ready) begin
                        valid_d = 1'b0;
                        ptr_d   = SW'(slot_q + 1'b1);
                        if (count_q != 8'hFF) begin
                            count_d = 8'(count_q + 8'd1);
                        end
                        state_d = WAIT;
                    end
                end
                default: begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            ptr_q   <= '0;
            probe_q <= '0;
            tries_q <= '0;
            slot_q  <= '0;
            x_q     <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            ptr_q   <= ptr_d;
            probe_q <= probe_d;
            tries_q <= tries_d;
            slot_q  <= slot_d;
            x_q     <= x_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_slot  = slot_q;
    assign spawn_x     = x_q;
    assign spawn_count = count_q;

endmodule

// File: tb/tb_meteor_spawn_scheduler.sv
// Scoreboard bench for meteor_spawn_scheduler: stimulus queues expected spawns, a monitor checks handshakes.
`timescale 1ns/1ps
module tb_meteor_spawn_scheduler;

    localparam int unsigned NS   = 8;
    localparam logic [9:0]  SEED = 10'h2A5;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          frame_tick;
    logic          game_active;
    logic [NS-1:0] slot_busy;
    logic          spawn_ready;
    logic          spawn_valid;
    logic [2:0]    spawn_slot;
    logic [9:0]    spawn_x;
    logic [7:0]    spawn_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] slot;
        logic [7:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    always #5 Clk = ~Clk;

    meteor_spawn_scheduler #(
        .NUM_SLOTS      (NS),
        .SPAWN_INTERVAL (4),
        .MIN_INTERVAL   (2),
        .LFSR_SEED      (SEED)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .game_active (game_active),
        .slot_busy   (slot_busy),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_slot  (spawn_slot),
        .spawn_x     (spawn_x),
        .spawn_count (spawn_count)
    );

    // Reference LFSR: Fibonacci, taps 10 and 7, shift left each clock.
    logic [9:0] m_lfsr;
    logic [9:0] m_prev;
    always @(posedge Clk) begin
        if (Reset) begin
            m_lfsr <= SEED;
            m_prev <= SEED;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [2:0] s, input logic [7:0] c);
        exp_t e;
        e.slot = s;
        e.cnt  = c;
        exp_q.push_back(e);
    endtask

    // Monitor: pops the scoreboard on every accepted command.
    logic       valid_prev = 1'b0;
    logic [9:0] exp_x = '0;
    logic       cnt_pend = 1'b0;
    logic [7:0] cnt_exp = '0;
    always @(negedge Clk) begin
        exp_t e;
        if (cnt_pend) begin
            check("count_after_accept", 32'(spawn_count), 32'(cnt_exp));
            cnt_pend = 1'b0;
        end
        if (Reset) begin
            valid_prev = 1'b0;
        end else begin
            if (spawn_valid && !valid_prev) begin
                exp_x = (m_prev < 10'd608) ? m_prev : 10'(m_prev - 10'd512);
            end
            if (spawn_valid && spawn_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_spawn", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("spawn_slot", 32'(spawn_slot), 32'(e.slot));
                    check("spawn_x", 32'(spawn_x), 32'(exp_x));
                    cnt_exp  = e.cnt;
                    cnt_pend = 1'b1;
                end
            end
            valid_prev = spawn_valid;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Four frame ticks, then measure clocks from the expiring tick to first spawn_valid (0 = none).
    task automatic interval_run(input int exp_lat, input string name);
        int first;
        first = 0;
        for (int t = 0; t < 4; t++) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            if (t < 3) cyc(1);
        end
        for (int j = 1; j <= NS + 4; j++) begin
            @(negedge Clk);
            if (spawn_valid && first == 0) first = j;
        end
        @(posedge Clk);
        #1;
        check(name, 32'(first), 32'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] held_slot;
        logic [9:0] held_x;

        Reset       = 1'b1;
        frame_tick  = 1'b0;
        game_active = 1'b0;
        spawn_ready = 1'b1;
        slot_busy   = '0;
        cyc(3);
        @(negedge Clk);
        check("rst_valid", 32'(spawn_valid), 32'd0);
        check("rst_slot", 32'(spawn_slot), 32'd0);
        check("rst_x", 32'(spawn_x), 32'd0);
        check("rst_count", 32'(spawn_count), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cyc(2);

        game_active = 1'b1;
        cyc(1);
        push_exp(3'd0, 8'd1);
        interval_run(2, "lat_first");

        for (int s = 1; s <= 8; s++) begin
            push_exp(3'(s % 8), 8'(s + 1));
            interval_run(2, "lat_round_robin");
        end

        slot_busy = 8'hFF;
        interval_run(0, "lat_all_busy");

        slot_busy = 8'b1101_1111;
        push_exp(3'd5, 8'd10);
        interval_run(6, "lat_slot5");

        slot_busy   = '0;
        spawn_ready = 1'b0;
        push_exp(3'd6, 8'd11);
        interval_run(2, "lat_hold");
        @(negedge Clk);
        held_slot = spawn_slot;
        held_x    = spawn_x;
        check("hold_slot_start", 32'(held_slot), 32'd6);
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            check("hold_valid", 32'(spawn_valid), 32'd1);
            check("hold_slot", 32'(spawn_slot), 32'(held_slot));
            check("hold_x", 32'(spawn_x), 32'(held_x));
        end
        @(posedge Clk);
        #1;
        spawn_ready = 1'b1;
        cyc(3);
        check("valid_after_accept", 32'(spawn_valid), 32'd0);

        spawn_ready = 1'b0;
        interval_run(2, "lat_drop");
        game_active = 1'b0;
        @(negedge Clk);
        check("drop_valid_same_cycle", 32'(spawn_valid), 32'd1);
        @(negedge Clk);
        check("drop_valid_next", 32'(spawn_valid), 32'd0);
        check("drop_count_kept", 32'(spawn_count), 32'd11);
        @(posedge Clk);
        #1;
        spawn_ready = 1'b1;
        cyc(2);
        check("idle_valid", 32'(spawn_valid), 32'd0);

        game_active = 1'b1;
        cyc(1);
        @(negedge Clk);
        check("restart_count_clear", 32'(spawn_count), 32'd0);
        @(posedge Clk);
        #1;
        push_exp(3'd0, 8'd1);
        interval_run(2, "lat_restart");
        cyc(2);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
